// File: rtl/sr_ff_bank.sv
// sr_ff_bank: a bank of independent SR flip-flops with a build-time policy for
// the S=R=1 conflict. Alongside the channel states it keeps a registered
// population count, a nonzero flag, a one-cycle rising-edge interrupt, and the
// index of the first channel to rise since the bank was last all-zero.
module sr_ff_bank #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int IW    = $clog2(WIDTH),
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] Q,
  output logic [CW-1:0]    cnt,
  output logic             any_set,
  output logic [IW-1:0]    first_idx,
  output logic             first_valid,
  output logic             irq
);

  // Conflict policy applied when a channel sees s=1 and r=1 together.
  typedef enum logic [1:0] {
    CONFLICT_HOLD   = 2'd0,
    CONFLICT_SET    = 2'd1,
    CONFLICT_RESET  = 2'd2,
    CONFLICT_TOGGLE = 2'd3
  } conflict_e;

  localparam logic [1:0] MODE_BITS = MODE[1:0];
  localparam conflict_e  POLICY    = conflict_e'(MODE_BITS);

  logic [WIDTH-1:0] q_next;    // channel states after this edge
  logic [WIDTH-1:0] rise;      // channels going 0->1 on this edge
  logic [IW-1:0]    rise_idx;  // lowest index among rising channels
  logic             rise_any;

  // Number of ones in a channel vector; the result width holds WIDTH itself,
  // so an all-ones bank reports WIDTH rather than wrapping to zero.
  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  // Per-channel next state from the s/r request pair and the conflict policy.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    q_next = Q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s[i], r[i]})
        2'b10:   q_next[i] = 1'b1;
        2'b01:   q_next[i] = 1'b0;
        2'b11: begin
          case (POLICY)
            CONFLICT_HOLD:   q_next[i] = Q[i];
            CONFLICT_SET:    q_next[i] = 1'b1;
            CONFLICT_RESET:  q_next[i] = 1'b0;
            CONFLICT_TOGGLE: q_next[i] = ~Q[i];
            default:         q_next[i] = Q[i];
          endcase
        end
        default: q_next[i] = Q[i];
      endcase
    end
  end

  // Rising-edge detect and lowest-index priority encode; scanning downward
  // lets the lowest rising channel overwrite any higher one.
  always_comb begin
    rise     = q_next & ~Q;
    rise_any = |rise;
    rise_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rise[i]) begin
        rise_idx = IW'(i);
      end
    end
  end

  // State registers: synchronous reset, then enable-gated update. Summary
  // outputs are derived from q_next so they always agree with Q.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      Q           <= '0;
      cnt         <= '0;
      any_set     <= 1'b0;
      first_idx   <= '0;
      first_valid <= 1'b0;
      irq         <= 1'b0;
    end else if (en) begin
      Q       <= q_next;
      cnt     <= popcount(q_next);
      any_set <= |q_next;
      irq     <= rise_any;
      if (q_next == '0) begin
        // Bank went idle: drop the captured index so the next rise re-arms.
        first_valid <= 1'b0;
        first_idx   <= '0;
      end else if (!first_valid && rise_any) begin
        first_valid <= 1'b1;
        first_idx   <= rise_idx;
      end
    end else begin
      // Frozen cycle: state holds, and the interrupt pulse must not stretch.
      irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: four instances (one per conflict MODE) share
// the same stimulus; expected values are hand-computed constants.
module tb_sr_ff_bank;

  localparam int WIDTH = 8;
  localparam int IW    = $clog2(WIDTH);
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;

  logic [WIDTH-1:0] q           [4];
  logic [CW-1:0]    cnt         [4];
  logic             any_set     [4];
  logic [IW-1:0]    first_idx   [4];
  logic             first_valid [4];
  logic             irq         [4];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_ff_bank #(.WIDTH(WIDTH), .MODE(m)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .s           (s),
      .r           (r),
      .Q           (q[m]),
      .cnt         (cnt[m]),
      .any_set     (any_set[m]),
      .first_idx   (first_idx[m]),
      .first_valid (first_valid[m]),
      .irq         (irq[m])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output check of the MODE 0 instance.
  task automatic check_main(input string tag, input logic [7:0] eq, input int ecnt,
                            input logic eany, input int eidx, input logic efv,
                            input logic eirq);
    check({tag, ".q"},   32'(q[0]),           32'(eq));
    check({tag, ".cnt"}, 32'(cnt[0]),         32'(ecnt));
    check({tag, ".any"}, 32'(any_set[0]),     32'(eany));
    check({tag, ".idx"}, 32'(first_idx[0]),   32'(eidx));
    check({tag, ".fv"},  32'(first_valid[0]), 32'(efv));
    check({tag, ".irq"}, 32'(irq[0]),         32'(eirq));
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; s = 8'hFF; r = 8'h00;
    tick();
    check_main("reset", 8'h00, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int m = 1; m < 4; m++) check($sformatf("reset.q%0d", m), 32'(q[m]), 32'h0);

    // First rise: channels 2 and 5, lowest is 2.
    reset = 1'b1; s = 8'h24; r = 8'h00;
    tick();
    check_main("set24", 8'h24, 2, 1'b1, 2, 1'b1, 1'b1);

    s = 8'h00;
    tick();
    check_main("idle", 8'h24, 2, 1'b1, 2, 1'b1, 1'b0);

    // Later rise does not move the captured index.
    s = 8'h01;
    tick();
    check_main("set01", 8'h25, 3, 1'b1, 2, 1'b1, 1'b1);

    // Falling-only update to all-zero clears the capture, no irq.
    s = 8'h00; r = 8'h25;
    tick();
    check_main("clr25", 8'h00, 0, 1'b0, 0, 1'b0, 1'b0);

    s = 8'h03; r = 8'h00;
    tick();
    check_main("set03", 8'h03, 2, 1'b1, 0, 1'b1, 1'b1);

    // Conflict s=r=0F from Q=03 under each MODE.
    s = 8'h0F; r = 8'h0F;
    tick();
    check("conf.m0.q",   32'(q[0]),   32'h03);
    check("conf.m0.irq", 32'(irq[0]), 32'h0);
    check("conf.m1.q",   32'(q[1]),   32'h0F);
    check("conf.m1.cnt", 32'(cnt[1]), 32'd4);
    check("conf.m1.irq", 32'(irq[1]), 32'h1);
    check("conf.m2.q",   32'(q[2]),   32'h00);
    check("conf.m2.fv",  32'(first_valid[2]), 32'h0);
    check("conf.m2.irq", 32'(irq[2]), 32'h0);
    check("conf.m3.q",   32'(q[3]),   32'h0C);
    check("conf.m3.irq", 32'(irq[3]), 32'h1);
    check("conf.m3.idx", 32'(first_idx[3]), 32'd0);

    // Produce an irq, then freeze with en=0: state holds, irq drops.
    s = 8'h04; r = 8'h00;
    tick();
    check_main("set04", 8'h07, 3, 1'b1, 0, 1'b1, 1'b1);

    en = 1'b0; s = 8'hFF;
    tick();
    check_main("frozen", 8'h07, 3, 1'b1, 0, 1'b1, 1'b0);

    en = 1'b1;
    tick();
    check_main("allones", 8'hFF, 8, 1'b1, 0, 1'b1, 1'b1);

    // Reset asserted between edges takes effect only at the next edge.
    reset = 1'b0; s = 8'h00; r = 8'h00;
    #3;
    check("rst_mid.q",   32'(q[0]),   32'hFF);
    check("rst_mid.cnt", 32'(cnt[0]), 32'd8);
    tick();
    check_main("rst_ff", 8'h00, 0, 1'b0, 0, 1'b0, 1'b0);

    // First edge after release processes s normally.
    reset = 1'b1; s = 8'h80;
    tick();
    check_main("set80", 8'h80, 1, 1'b1, 7, 1'b1, 1'b1);

    // Old bit cleared while a new one rises: capture already valid, index kept.
    s = 8'h01; r = 8'h80;
    tick();
    check_main("swap", 8'h01, 1, 1'b1, 7, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
SR_FF_BANK -- requirements
Module: sr_ff_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of independent SR channels, legal range 2..32.
REQ-002 Parameter MODE, default 0, S=R=1 conflict policy: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
REQ-003 Parameter IW, default $clog2(WIDTH), width of first_idx; CW, default $clog2(WIDTH+1), width of cnt.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-006 en  input  1  global update enable; 0 freezes all state.
REQ-007 s  input  WIDTH  per-channel set request.
REQ-008 r  input  WIDTH  per-channel reset request.
REQ-009 Q  output  WIDTH  registered channel states.
REQ-010 cnt  output  CW  registered count of ones in Q.
REQ-011 any_set  output  1  registered, high when Q is nonzero.
REQ-012 first_idx  output  IW  index of first channel to rise since bank was last all-zero.
REQ-013 first_valid  output  1  first_idx holds a captured index.
REQ-014 irq  output  1  one-cycle pulse, registered, marking any 0->1 channel transition.

Function
REQ-015 Per channel with en=1: s=0,r=0 holds; s=1,r=0 sets; s=0,r=1 clears; s=1,r=1 follows MODE.
REQ-016 MODE 3 with s=r=1 SHALL invert that channel's Q.
REQ-017 With en=0, Q, cnt, any_set, first_idx, first_valid SHALL hold; irq SHALL be 0.
REQ-018 Q SHALL update on the rising edge where inputs are sampled; latency one cycle.
REQ-019 cnt and any_set SHALL be registered from next-state Q, always consistent with Q in the same cycle.
REQ-020 irq SHALL be 1 exactly in the cycle after an edge where at least one channel went 0->1, else 0.
REQ-021 Falling-only or unchanged updates SHALL leave irq at 0.
REQ-022 Capture: when first_valid=0 and at least one channel rises, first_idx SHALL take the lowest rising index and first_valid SHALL go 1 in the same cycle as Q.
REQ-023 While first_valid=1, further rises SHALL NOT change first_idx.
REQ-024 When next-state Q is all-zero, first_valid SHALL clear to 0 and first_idx to 0 on that edge.
REQ-025 Simultaneous all-zero and rise impossible by construction; a clear of all old bits with a new rise SHALL re-arm: first_valid stays/becomes 1 with the new lowest rising index only if first_valid was 0.
REQ-026 cnt SHALL reach WIDTH with no wrap; all-ones Q gives cnt=WIDTH.
REQ-027 Channels SHALL be fully independent; no cross-channel priority except first_idx tie-break.

Reset
REQ-028 reset=0 at a rising edge SHALL force Q=0, cnt=0, any_set=0, first_idx=0, first_valid=0, irq=0, overriding en, s, r.
REQ-029 Reset asserted mid-operation SHALL take effect at the next edge only; outputs unchanged between edges.
REQ-030 First edge after reset release SHALL process s/r normally.

Verification
REQ-031 WIDTH=8, MODE=0: reset=0 one edge with s=8'hFF -> Q=00, cnt=0, irq=0, first_valid=0.
REQ-032 s=8'h24, r=0, en=1 -> next cycle Q=24, cnt=2, any_set=1, irq=1, first_idx=2, first_valid=1; following idle cycle irq=0.
REQ-033 Then s=8'h01 -> Q=25, cnt=3, irq=1, first_idx stays 2; then r=8'h25 -> Q=00, first_valid=0, irq=0.
REQ-034 s=r=8'h0F from Q=8'h03, per MODE: 0 -> 03; 1 -> 0F; 2 -> 00; 3 -> 0C with irq=1.
REQ-035 en=0 with s=8'hFF -> Q, cnt, first_idx unchanged, irq=0; then en=1 -> Q=FF, cnt=8.
REQ-036 From Q=8'hFF, assert reset=0 for one edge with r=0 -> all outputs zero next cycle; release, s=8'h80 -> first_idx=7, cnt=1.
